// File: rtl/work_loader.sv
// -----------------------------------------------------------------------------
// work_loader
//
// Loads one mining work unit from a stream of 32-bit header words. The first
// MID_WORDS accepted words are shifted into the midstate register and the next
// TAIL_WORDS into the block-tail register. Each register holds its first word
// in the MSBs. The shift timer is driven through controller_state so that it
// counts exactly the accepted words. The timer's done flags then sequence the
// load. A finished unit is offered to the hash core with work_valid and is
// released by work_accept.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   synchronous active-high reset
//   start                 begin a new load (sampled in IDLE only)
//   abort                 abandon the current load, return to IDLE
//   word_in/word_valid    header word input, qualified by word_valid
//   word_ready            word taken when word_valid && word_ready
//   midstate_shifts_done  timer flag: MID_WORDS words counted
//   remaining_shifts_done timer flag: MID_WORDS+TAIL_WORDS words counted
//   controller_state      timer control code (000 clears it; 001/010 count)
//   work_valid            midstate/block_tail hold a complete work unit
//   work_accept           hash core takes the work unit
//   midstate, block_tail  loaded data
//   busy                  high in any state other than IDLE
//
// Build option:
//   WORK_LOADER_BYTESWAP_EN  byte-reverse every accepted word before shifting
//                            (little-endian host header order)
// -----------------------------------------------------------------------------
module work_loader #(
   parameter int WORD_W     = 32,
   parameter int MID_WORDS  = 8,
   parameter int TAIL_WORDS = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [WORD_W-1:0]            word_in,
   input  logic                         word_valid,
   output logic                         word_ready,
   input  logic                         midstate_shifts_done,
   input  logic                         remaining_shifts_done,
   output logic [2:0]                   controller_state,
   output logic                         work_valid,
   input  logic                         work_accept,
   output logic [MID_WORDS*WORD_W-1:0]  midstate,
   output logic [TAIL_WORDS*WORD_W-1:0] block_tail,
   output logic                         busy
);

   localparam int MID_W  = MID_WORDS * WORD_W;
   localparam int TAIL_W = TAIL_WORDS * WORD_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_MID = 2'd1,
      LOAD_REM = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;
   logic                accept;
   logic [WORD_W-1:0]   word_shift;

   // Word as it enters the shift registers.
`ifdef WORK_LOADER_BYTESWAP_EN
   always_comb begin
      // NOTE: every bit is assigned on each pass through this block, so no
      // latch is inferred; the same rule holds for all always_comb blocks here.
      word_shift = '0;
      for (int i = 0; i < WORD_W / 8; i++) begin
         word_shift[i*8 +: 8] = word_in[WORD_W-8-i*8 +: 8];
      end
   end
`else
   assign word_shift = word_in;
`endif

   // Ready comes from state and the timer flags only, never from word_valid,
   // so the source may wait for ready without a combinational loop.
   always_comb begin
      word_ready = 1'b0;
      case (state)
         LOAD_MID: word_ready = !midstate_shifts_done;
         LOAD_REM: word_ready = !remaining_shifts_done;
         default:  word_ready = 1'b0;
      endcase
   end

   assign accept = word_valid && word_ready;
   assign busy   = (state != IDLE);

   // Mealy timer code: the timer advances only in cycles that take a word.
   always_comb begin
      controller_state = 3'b000;
      case (state)
         IDLE:     controller_state = 3'b000;
         LOAD_MID: controller_state = accept ? 3'b001 : 3'b011;
         LOAD_REM: controller_state = accept ? 3'b010 : 3'b100;
         DONE:     controller_state = 3'b101;
         default:  controller_state = 3'b000;
      endcase
   end

   // Next state. abort overrides everything, including start in IDLE. The
   // done flag that is not expected in the current state is ignored.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:     if (start)                 state_next = LOAD_MID;
            LOAD_MID: if (midstate_shifts_done)  state_next = LOAD_REM;
            LOAD_REM: if (remaining_shifts_done) state_next = DONE;
            DONE:     if (work_accept)           state_next = IDLE;
            default:                             state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the data registers are reset here because they are plain
         // flops. They are also visible outputs and must read 0 after reset.
         state      <= IDLE;
         work_valid <= 1'b0;
         midstate   <= '0;
         block_tail <= '0;
      end else begin
         state      <= state_next;
         // Registered copy of (state == DONE), aligned with the state flop.
         work_valid <= (state_next == DONE);
         if (accept && state == LOAD_MID) begin
            midstate <= {midstate[MID_W-WORD_W-1:0], word_shift};
         end
         if (accept && state == LOAD_REM) begin
            block_tail <= {block_tail[TAIL_W-WORD_W-1:0], word_shift};
         end
      end
   end

endmodule
